// File: rtl/audio_vis_pkg.sv
// Shared types and constants for the audio-to-display sample path:
// feeder FSM states, mono sample width and codec word slicing.
package audio_vis_pkg;

   localparam int AUDIO_SAMPLE_W   = 16;
   localparam int CODEC_DATA_W     = 32;
   localparam int CODEC_SAMPLE_MSB = 31;
   localparam int CODEC_SAMPLE_LSB = 16;

   typedef enum logic [0:0] {
      FEED_ACCUM   = 1'b0,
      FEED_PENDING = 1'b1
   } feed_state_t;

endpackage

// File: rtl/stereo_to_mono.sv
// Combinational left/right mix: 17-bit signed sum of the codec upper halves,
// halved with an arithmetic shift so the mono result never overflows.
module stereo_to_mono
   import audio_vis_pkg::*;
(
   input  logic        [CODEC_DATA_W-1:0]   i_left,
   input  logic        [CODEC_DATA_W-1:0]   i_right,
   output logic signed [AUDIO_SAMPLE_W-1:0] o_mono
);

   logic signed [AUDIO_SAMPLE_W:0]       w_left;
   logic signed [AUDIO_SAMPLE_W:0]       w_right;
   logic signed [AUDIO_SAMPLE_W:0]       w_sum;
   logic [2*CODEC_SAMPLE_LSB-1:0]        w_unused_lo;

   assign w_left  = {i_left[CODEC_SAMPLE_MSB],  i_left[CODEC_SAMPLE_MSB:CODEC_SAMPLE_LSB]};
   assign w_right = {i_right[CODEC_SAMPLE_MSB], i_right[CODEC_SAMPLE_MSB:CODEC_SAMPLE_LSB]};
   assign w_sum   = w_left + w_right;
   // Dropping bit 0 of the 17-bit sum is the floor-halving shift.
   assign o_mono  = w_sum[AUDIO_SAMPLE_W:1];

   assign w_unused_lo = {i_left[CODEC_SAMPLE_LSB-1:0], i_right[CODEC_SAMPLE_LSB-1:0]};

endmodule

// File: rtl/audio_sample_feeder.sv
// Drains the codec FIFO, decimates mono samples per block and holds the result
// for the display. Define AUDIO_PEAK_HOLD_EN to select block peak instead of mean.
module audio_sample_feeder
   import audio_vis_pkg::*;
#(
   parameter int DECIM_LOG2 = 4,
   parameter int SAMPLE_W   = AUDIO_SAMPLE_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pause,
   input  logic                       read_ready,
   input  logic [CODEC_DATA_W-1:0]    left_in,
   input  logic [CODEC_DATA_W-1:0]    right_in,
   output logic                       read,
   input  logic                       sample_ack,
   output logic signed [SAMPLE_W-1:0] data_audio_out,
   output logic                       new_sample,
   output logic                       overrun
);

   localparam int               CNT_W    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int               ACC_W    = SAMPLE_W + DECIM_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

   logic signed [AUDIO_SAMPLE_W-1:0] w_mono;
   logic signed [SAMPLE_W-1:0]       w_mono_ext;
   logic signed [SAMPLE_W-1:0]       w_block;
   logic                             w_accept;
   logic                             w_done;
   logic                             w_take;

   feed_state_t                r_state;
   logic [CNT_W-1:0]           r_cnt;
   logic signed [SAMPLE_W-1:0] r_pending;
   logic signed [SAMPLE_W-1:0] r_out;
   logic                       r_new;
   logic                       r_overrun;

   stereo_to_mono u_mix (
      .i_left  (left_in),
      .i_right (right_in),
      .o_mono  (w_mono)
   );

   assign read       = read_ready & ~reset;
   assign w_mono_ext = SAMPLE_W'(w_mono);
   assign w_accept   = read & ~pause;
   assign w_done     = w_accept & (r_cnt == CNT_LAST);
   assign w_take     = (r_state == FEED_PENDING) & sample_ack;

`ifdef AUDIO_PEAK_HOLD_EN
   logic signed [SAMPLE_W-1:0] r_peak;

   function automatic logic [SAMPLE_W:0] mag(input logic signed [SAMPLE_W-1:0] v);
      logic signed [SAMPLE_W:0] x;
      x = {v[SAMPLE_W-1], v};
      return (x < $signed({(SAMPLE_W+1){1'b0}})) ? -x : x;
   endfunction

   // The first sample of a block always seeds the peak; later ones must be strictly larger.
   assign w_block = ((r_cnt == {CNT_W{1'b0}}) || (mag(w_mono_ext) > mag(r_peak))) ? w_mono_ext : r_peak;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt  <= {CNT_W{1'b0}};
         r_peak <= {SAMPLE_W{1'b0}};
      end else if (w_accept) begin
         if (w_done) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_peak <= {SAMPLE_W{1'b0}};
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_peak <= w_block;
         end
      end
   end
`else
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_sum;

   assign w_sum   = r_acc + ACC_W'(w_mono_ext);
   // Slicing above the low bits is the floor (toward -inf) division by the block length.
   assign w_block = w_sum[DECIM_LOG2 +: SAMPLE_W];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= {CNT_W{1'b0}};
         r_acc <= {ACC_W{1'b0}};
      end else if (w_accept) begin
         if (w_done) begin
            r_cnt <= {CNT_W{1'b0}};
            r_acc <= {ACC_W{1'b0}};
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_sum;
         end
      end
   end
`endif

   // Handshake FSM; a completion in the same cycle as an ack keeps the state PENDING.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= FEED_ACCUM;
         r_pending <= {SAMPLE_W{1'b0}};
         r_out     <= {SAMPLE_W{1'b0}};
         r_new     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_new <= 1'b0;
         if (!pause) begin
            if (w_take) begin
               r_out <= r_pending;
               r_new <= 1'b1;
            end
            if (w_done) begin
               r_pending <= w_block;
               r_state   <= FEED_PENDING;
               if ((r_state == FEED_PENDING) && !w_take) begin
                  r_overrun <= 1'b1;
               end
            end else if (w_take) begin
               r_state <= FEED_ACCUM;
            end
         end
      end
   end

   assign data_audio_out = r_out;
   assign new_sample     = r_new;
   assign overrun        = r_overrun;

endmodule

// File: doc/audio_sample_feeder.md
# audio_sample_feeder

Producer side of the audio-to-display sample path. Drains the audio codec's input FIFO and mixes left/right to mono. Decimates by block-averaging to one 16-bit sample per block, and hands that sample to the VGA plotting block through a request/ack hold register. The plotting block reads a value that stays stable for a whole column.

## Interface
- DECIM_LOG2, default 4: block length is 2^DECIM_LOG2 codec samples; legal range 0..8.
- SAMPLE_W, default 16: width of the mono sample and of `data_audio_out`.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pause  in  1  freezes accumulation and output updates; the codec is still drained.
- read_ready  in  1  codec FIFO holds a sample; `left_in`/`right_in` are valid this cycle.
- left_in  in  32  codec left channel, signed; bits [31:16] are used.
- right_in  in  32  codec right channel, signed; bits [31:16] are used.
- read  out  1  pops one codec sample this cycle.
- sample_ack  in  1  one-cycle pulse from the display at the start of a column.
- data_audio_out  out  SAMPLE_W  held signed sample for the display.
- new_sample  out  1  one-cycle pulse when `data_audio_out` has just been updated.
- overrun  out  1  sticky: a completed block overwrote a pending, unacknowledged block.

## Operation
- `read = read_ready & ~reset`, combinational.
  - The codec is drained every cycle it has data, in every state, so the FIFO never stalls.
- Sample acceptance:
  - A sample is accepted when `read` is high and `pause` is low.
  - When `pause` is high, popped samples are discarded.
- Mono mix: `mono = (sext17(left_in[31:16]) + sext17(right_in[31:16])) >>> 1`.
  - The sum uses 17-bit signed arithmetic, so it never overflows.
  - The result is 16-bit signed.
- Accumulation:
  - Accumulator is signed, SAMPLE_W+DECIM_LOG2 bits; block counter is DECIM_LOG2 bits.
  - Each accepted sample adds `mono` to the accumulator and increments the counter.
- Block completion (the counter wraps from 2^DECIM_LOG2−1 to 0):
  - `pending = (acc + mono) >>> DECIM_LOG2`; arithmetic shift, so division rounds toward −inf.
  - The accumulator restarts at 0.
- FSM states:
  - ACCUM: no result pending.
    - Block completion → PENDING.
    - `sample_ack` is ignored.
  - PENDING: a result is waiting.
    - `sample_ack` with `pause` low copies `pending` to `data_audio_out`, pulses `new_sample` and moves to ACCUM.
    - Block completion without ack overwrites `pending`, sets `overrun` and stays in PENDING (latest block wins).
    - Ack and completion in the same cycle: the output takes the old `pending`, `pending` takes the new block, and the state stays PENDING.
- `pause` high holds the FSM, counter, accumulator and `pending`, and ignores `sample_ack`.
- Reset values:
  - `data_audio_out` = 0, `new_sample` = 0, `overrun` = 0.
  - State ACCUM; accumulator, counter and `pending` all 0.
- Reset mid-block discards the partial block, with no output change beyond the reset values.
- `overrun` is cleared only by reset.

## Timing
- Acceptance is in the same cycle as `read_ready`; there is no extra handshake delay on the codec side.
- `pending` and the PENDING state become valid at the clock edge that ends the cycle in which the last sample of the block is accepted.
- `data_audio_out` and `new_sample` update at the clock edge that ends the `sample_ack` cycle.
  - `new_sample` is high for exactly one cycle.
- Minimum latency from the last sample of a block to the output is 2 edges, when ack arrives the cycle after completion.
- Throughput: one codec sample per clock; there is no back-pressure.
- DECIM_LOG2 = 0: every accepted sample completes a block, and `pending = mono`.

## Configuration
- `AUDIO_PEAK_HOLD_EN` defined:
  - The block result is the sample of largest magnitude in the block, with its sign kept.
  - On a tie, the earliest sample is kept.
  - The accumulator is replaced by a SAMPLE_W peak register plus a magnitude compare.
- Not defined: the block result is the arithmetic mean as described above.
- Handshake, FSM and timing are identical in both builds.

## Structure
- Shared package `audio_vis_pkg` holds:
  - the FSM state enum (`FEED_ACCUM`, `FEED_PENDING`);
  - `AUDIO_SAMPLE_W` = 16;
  - the codec data width (32) and the codec sample slice constants, for use by the display block as well.
- One sub-module, `stereo_to_mono`: combinational 17-bit mix and shift, instantiated once.
- The FSM, accumulator/peak logic and hold register stay in the top module.

## Test plan
All scenarios use DECIM_LOG2 = 2 and `left_in == right_in` unless stated.
- Reset, then 4 accepted samples with upper half 0x0100, then ack → `data_audio_out` = 0x0100 and one-cycle `new_sample` at the edge after the ack; `read` tracks `read_ready` throughout.
- Extremes: 4 samples of 0x7FFF → 0x7FFF; 4 samples of 0x8000 → 0x8000; left 0x7FFF with right 0x8000 → 0xFFFF.
- Samples 4, −8, 12, −16, then ack:
  - mean build → 0xFFFE;
  - `AUDIO_PEAK_HOLD_EN` build → 0xFFF0.
- Two full blocks (all 1, then all 3) before any ack → `overrun` = 1 and the ack yields 3.
- Ack in the same cycle as the completion of a second block:
  - output = first block;
  - state stays PENDING;
  - the next ack outputs the second block.
- Pause and reset checks:
  - `pause` high for 3 `read_ready` cycles → `read` still asserted, counter unchanged, ack ignored.
  - Reset after 2 samples, then 4 samples of 0x0010 → result 0x0010.
